// File: rtl/perf_counter_bank.sv
// ---------------------------------------------------------------------------
// perf_counter_bank
//
// Event-counter bank for the pipelined MIPS CPU. It holds N_CH live counters
// of CNT_W bits. Each counter can wrap or saturate, and each has a sticky
// overflow flag. Every counter also has a shadow copy that the LED/display
// path reads back through a registered read port.
//
// A small run-control FSM gates counting:
//   IDLE (0) -> RUN (1) on start.
//   RUN -> HALTED (2) when halt is seen. This entry also takes an
//                     automatic snapshot.
//   HALTED -> RUN on go, but only while halt is low.
//   Any state -> IDLE on clr_cnt.
//
// The control inputs start, go, snap and clr_cnt are single-cycle pulse
// requests. They have no handshake: each one is sampled on every rising
// edge, and a level held for n cycles acts as n requests.
//
// Ports
//   clk        system clock, all state updates on the rising edge
//   clr        asynchronous active-high reset
//   start      pulse, IDLE -> RUN
//   halt       level, CPU halted on syscall (freeze request)
//   go         pulse, HALTED -> RUN when halt is low
//   clr_cnt    synchronous clear of counters, shadows and flags; FSM -> IDLE
//   snap       pulse, copy live counters into shadows
//   evt        per-channel event strobes
//   ch_en      per-channel count enables
//   rd_sel     channel to read back
//   rd_data    registered shadow value of channel rd_sel (0 if out of range)
//   rd_ovf     registered overflow flag of channel rd_sel (0 if out of range)
//   ovf        sticky overflow flags, all channels
//   state      FSM state: IDLE=0, RUN=1, HALTED=2
//   snap_done  one-cycle pulse after any snapshot
// ---------------------------------------------------------------------------
module perf_counter_bank #(
    parameter int N_CH     = 8,
    parameter int CNT_W    = 32,
    parameter int SAT_MODE = 0,
    parameter int SEL_W    = $clog2(N_CH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             halt,
    input  logic             go,
    input  logic             clr_cnt,
    input  logic             snap,
    input  logic [N_CH-1:0]  evt,
    input  logic [N_CH-1:0]  ch_en,
    input  logic [SEL_W-1:0] rd_sel,
    output logic [CNT_W-1:0] rd_data,
    output logic             rd_ovf,
    output logic [N_CH-1:0]  ovf,
    output logic [1:0]       state,
    output logic             snap_done
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2,
        ST_BAD    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt    [N_CH];
    logic [CNT_W-1:0] r_shadow [N_CH];
    logic [N_CH-1:0]  r_ovf;
    logic             r_snap_done;
    logic [CNT_W-1:0] r_rd_data;
    logic             r_rd_ovf;

    logic             w_count_en;
    logic             w_enter_halt;
    logic             w_take_snap;
    logic             w_sel_ok;
    logic [CNT_W-1:0] w_cnt_nxt [N_CH];
    logic [N_CH-1:0]  w_ovf_set;

    // The cycle in which halt is first seen in RUN does not count.
    assign w_count_en   = (r_state == ST_RUN) && !halt;
    assign w_enter_halt = (r_state == ST_RUN) && halt;
    // clr_cnt has priority and suppresses both manual and automatic snapshots.
    assign w_take_snap  = !clr_cnt && (snap || w_enter_halt);
    assign w_sel_ok     = (32'(rd_sel) < N_CH);

    // Next value of each live counter, including the overflow decision.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            w_cnt_nxt[i] = r_cnt[i];
            w_ovf_set[i] = 1'b0;
            if (w_count_en && evt[i] && ch_en[i]) begin
                if (r_cnt[i] == CNT_MAX) begin
                    w_cnt_nxt[i] = (SAT_MODE != 0) ? CNT_MAX : '0;
                    w_ovf_set[i] = 1'b1;
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Run-control FSM. Encoding 3 is unreachable and falls back to IDLE.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= ST_IDLE;
        end else if (clr_cnt) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:   if (start)        r_state <= ST_RUN;
                ST_RUN:    if (halt)         r_state <= ST_HALTED;
                ST_HALTED: if (go && !halt)  r_state <= ST_RUN;
                default:                     r_state <= ST_IDLE;
            endcase
        end
    end

    // Live counters, shadows and sticky flags. A shadow loads the post-increment
    // value, so an event in the snapshot cycle is included in the snapshot.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < N_CH; i++) begin
                r_cnt[i]    <= '0;
                r_shadow[i] <= '0;
            end
            r_ovf       <= '0;
            r_snap_done <= 1'b0;
        end else if (clr_cnt) begin
            for (int i = 0; i < N_CH; i++) begin
                r_cnt[i]    <= '0;
                r_shadow[i] <= '0;
            end
            r_ovf       <= '0;
            r_snap_done <= 1'b0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
                if (w_take_snap) begin
                    r_shadow[i] <= w_cnt_nxt[i];
                end
            end
            r_ovf       <= r_ovf | w_ovf_set;
            r_snap_done <= w_take_snap;
        end
    end

    // Registered read port. It reads the shadow register, so a snapshot taken
    // at edge k becomes visible here at edge k+1.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_rd_data <= '0;
            r_rd_ovf  <= 1'b0;
        end else if (w_sel_ok) begin
            r_rd_data <= r_shadow[rd_sel];
            r_rd_ovf  <= r_ovf[rd_sel];
        end else begin
            r_rd_data <= '0;
            r_rd_ovf  <= 1'b0;
        end
    end

    assign rd_data   = r_rd_data;
    assign rd_ovf    = r_rd_ovf;
    assign ovf       = r_ovf;
    assign state     = r_state;
    assign snap_done = r_snap_done;

endmodule
